four_bank_mem: RTL
==================

# four_bank_mem

Banked main-memory model and controller directly downstream of the direct-mapped cache FSM. Accepts one word read or write per cycle from the cache's `m_rd` / `m_wr` / `m_offset` path and steers it to one of four interleaved banks. Each bank is occupied for four cycles per access; read data returns with fixed latency. `stall` back-pressures the cache whenever the addressed bank is still busy.

## Interface
- `DEPTH_W`, default 13: per-bank address width. Each bank holds 2^DEPTH_W words.
- `clk`, input, 1: system clock. All state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-low (0 = reset).
- `addr`, input, 16: byte address.
  - `addr[2:1]` selects the bank.
  - `addr[DEPTH_W+2:3]` is the row within the bank.
  - `addr[0]` must be 0.
- `data_in`, input, 16: write data, sampled in the accept cycle.
- `wr`, input, 1: write request.
- `rd`, input, 1: read request.
- `data_out`, output, 16: read data. Valid only while `rd_valid`=1, otherwise 0.
- `rd_valid`, output, 1: one-cycle pulse qualifying `data_out`.
- `stall`, output, 1: request not accepted this cycle because the addressed bank is busy. Combinational from the request and bank state.
- `busy`, output, 4: per-bank busy flags, bit i for bank i.
- `err`, output, 1: one-cycle registered pulse flagging an illegal request.

## Operation
- **Request legality.** A request is a cycle with `rd`|`wr`=1. It is illegal if `rd`&`wr`=1 or `addr[0]`=1.
  - Illegal requests are never accepted.
  - `stall`=0 for illegal requests.
  - `err`=1 on the following cycle.
  - No bank state changes.
- **Acceptance.** A legal request is accepted in cycle T iff `busy[addr[2:1]]`=0; then `stall`=0. If the bank is busy, `stall`=1 and nothing happens; the requester holds its inputs and retries.
- **Bank occupancy.** Each bank has a 2-bit down-counter `cnt`.
  - `busy[i]` = (`cnt[i]` != 0).
  - On accept, `cnt` loads 3, so the bank is busy in T+1, T+2, T+3 and free again in T+4.
  - The counter decrements by 1 per cycle while nonzero.
- **Write.** The array row is written at the clock edge ending cycle T.
- **Read.**
  - The array is read at the end of T.
  - A 2-stage pipeline carries {valid, data}.
  - `rd_valid`=1 and `data_out` = row contents in cycle T+2, then both return to 0.
- **Read-after-write.** A read of a just-written address returns the new data. This is guaranteed because the same bank cannot accept again before T+4.
- **Back-to-back traffic.** Requests to different banks in consecutive cycles are all accepted with no stall. Cache line fill at offsets 0,1,2,3 in T..T+3 gives `rd_valid` in T+2..T+5.
- **Reset.** While `rst`=0:
  - All `cnt`=0, pipeline valids=0.
  - `busy`=0, `rd_valid`=0, `data_out`=0, `err`=0.
  - `stall`=0 whenever `busy`=0, so it reads 0 during reset.
  - In-flight reads are dropped.
  - Array contents are not reset; they are undefined until written.

## Timing
- Read latency: 2 cycles from accept to `rd_valid`. Write commits in the accept cycle.
- Bank occupancy: 4 cycles (accept + 3).
- Same-bank reissue: earliest accept is T+4. Requests in T+1..T+3 see `stall`=1.
- `stall`: combinational, same cycle as the request.
- `err`, `rd_valid`, `data_out`, `busy`: registered or decoded from registers. No combinational path from inputs.
- Simultaneous events in one cycle (accept to bank j, counter of bank k decrementing, read pipeline shifting) are independent and all occur.
- Reset deassertion: first accept possible in the first cycle with `rst`=1.

## Structure
- Shared package `mem_pkg`:
  - `BANKS`=4
  - `BANK_OCC`=4
  - `RD_LAT`=2
  - bank-select field position (bits 2:1)
  - word width 16
- Sub-module `mem_bank`, instantiated four times. It contains:
  - the storage array
  - the busy counter
  - its read-valid/data pipeline stage
  - outputs: `busy` and a registered data/valid pair
- Top level:
  - bank decode
  - legality check
  - `stall`/`err` generation
  - OR-merge of the bank read pipelines (at most one bank valid per cycle, because accepts are one per cycle)

## Test plan
- **Reset mid-read.** Accept read at T, assert `rst`=0 at T+1 → no `rd_valid` at T+2, `busy`=0, `data_out`=0.
- **Write/read one address.** Write 0xBEEF to 0x0010 at T; read 0x0010 at T+4 → `stall`=0, `rd_valid`=1 and `data_out`=0xBEEF at T+6.
- **Same-bank conflict.** Read 0x0000 at T, hold read 0x0008 (same bank 0) from T+1 → `stall`=1 in T+1..T+3, accepted at T+4, `rd_valid` at T+6.
- **Line fill.** Reads to 0x0020, 0x0022, 0x0024, 0x0026 in T..T+3 → `stall` never 1, `rd_valid` T+2..T+5 with the four stored words in order.
- **Illegal requests.** `rd`=`wr`=1, or read of 0x0011 → `stall`=0, `err`=1 next cycle, `busy` unchanged, no `rd_valid`.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the four-bank interleaved main memory.
package mem_pkg;

    localparam int unsigned BANKS    = 4;
    localparam int unsigned BANK_OCC = 4;  // cycles a bank is held per access
    localparam int unsigned RD_LAT   = 2;  // accept to rd_valid
    localparam int unsigned BANK_LSB = 1;
    localparam int unsigned BANK_MSB = 2;
    localparam int unsigned BANK_W   = BANK_MSB - BANK_LSB + 1;
    localparam int unsigned WORD_W   = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned CNT_W    = 2;

    typedef logic [WORD_W-1:0] word_t;

    // Busy counter load value: accept cycle plus BANK_OCC-1 busy cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_OCC - 1);

endpackage

// File: rtl/four_bank_mem_if.sv
// Request/response bus between the cache controller and the banked memory.
interface four_bank_mem_if;
    import mem_pkg::*;

    logic [ADDR_W-1:0] addr;
    word_t             data_in;
    logic              wr;
    logic              rd;
    word_t             data_out;
    logic              rd_valid;
    logic              stall;
    logic [BANKS-1:0]  busy;
    logic              err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, rd_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, rd_valid, stall, busy, err
    );

endinterface

// File: rtl/mem_bank.sv
// One memory bank: storage array, occupancy counter and first read stage.
module mem_bank
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acc_i,
    input  logic               we_i,
    input  logic [DEPTH_W-1:0] row_i,
    input  word_t              wdata_i,
    output logic               busy_o,
    output logic               rd_valid_o,
    output word_t              rd_data_o
);

    word_t            mem_q [2**DEPTH_W];
    word_t            data_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;

    // Occupancy counter reload on accept, count down while nonzero; read-valid stage.
    always_comb begin
        cnt_d = cnt_q;
        vld_d = acc_i && !we_i;
        if (acc_i) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state; in-flight reads are dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end

    // Storage array and synchronous read port; contents are not reset.
    always_ff @(posedge clk) begin
        if (acc_i && we_i) begin
            mem_q[row_i] <= wdata_i;
        end
        if (acc_i && !we_i) begin
            data_q <= mem_q[row_i];
        end
    end

    assign busy_o     = (cnt_q != '0);
    assign rd_valid_o = vld_q;
    // Masked so the top can simply OR the banks together.
    assign rd_data_o  = vld_q ? data_q : '0;

endmodule

// File: rtl/four_bank_mem.sv
// Four-bank interleaved memory controller: decode, legality, stall/err, read merge.
module four_bank_mem
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_W = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    four_bank_mem_if.slave        bus
);

    logic [BANK_W-1:0]  bank_sel;
    logic [DEPTH_W-1:0] row;
    logic               req, illegal, legal, accept;
    logic [BANKS-1:0]   bank_busy, bank_vld, bank_acc;
    word_t              bank_data [BANKS];
    logic               err_q, err_d;
    logic               rv_q, rv_d;
    word_t              dout_q, dout_d;

    assign bank_sel = bus.addr[BANK_MSB:BANK_LSB];
    assign row      = bus.addr[DEPTH_W+2:3];

    // Request decode, legality check and per-bank accept strobes.
    always_comb begin
        req     = bus.rd || bus.wr;
        illegal = (bus.rd && bus.wr) || bus.addr[0];
        legal   = req && !illegal;
        accept  = legal && !bank_busy[bank_sel];
        for (int i = 0; i < BANKS; i++) begin
            bank_acc[i] = accept && (bank_sel == BANK_W'(i));
        end
    end

    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        mem_bank #(
            .DEPTH_W (DEPTH_W)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .acc_i      (bank_acc[g]),
            .we_i       (bus.wr),
            .row_i      (row),
            .wdata_i    (bus.data_in),
            .busy_o     (bank_busy[g]),
            .rd_valid_o (bank_vld[g]),
            .rd_data_o  (bank_data[g])
        );
    end

    // Second read stage: OR-merge of bank stages (at most one valid per cycle) and err pulse.
    always_comb begin
        rv_d   = |bank_vld;
        dout_d = '0;
        for (int i = 0; i < BANKS; i++) begin
            dout_d = dout_d | bank_data[i];
        end
        err_d = req && illegal;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_q   <= 1'b0;
            dout_q <= '0;
            err_q  <= 1'b0;
        end else begin
            rv_q   <= rv_d;
            dout_q <= dout_d;
            err_q  <= err_d;
        end
    end

    assign bus.stall    = legal && bank_busy[bank_sel];
    assign bus.busy     = bank_busy;
    assign bus.rd_valid = rv_q;
    assign bus.data_out = dout_q;
    assign bus.err      = err_q;

endmodule
